bcd_display_n: RTL and testbench

Parametrised binary-to-decimal seven-segment driver for the DE2 HEX displays. Converts a WIDTH-bit unsigned or two's-complement value to DIGITS BCD digits with an iterative shift/add-3 FSM, then drives one active-low segment vector per digit plus a separate sign display. Adds a start/busy/done handshake, signed mode, leading-zero blanking and overflow indication. Sits between the datapath (e.g. mic level or counter output) and the HEX pins.

---
 rtl/bcd_disp_pkg.sv | 16 +
 rtl/seven_seg.sv | 27 ++
 rtl/bcd_display_n.sv | 137 +++++++++++++
 tb/tb_bcd_display_n.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the BCD display driver.
package bcd_disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADD3  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Active-low segment patterns, bit 0 = segment a, bit 6 = segment g.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

endpackage

// File: rtl/seven_seg.sv
// Active-low seven-segment decoder for one BCD digit; non-decimal codes show blank.
module seven_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Digit-to-pattern lookup
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_ZERO;
            4'd1:    seg_o = 7'h79;
            4'd2:    seg_o = 7'h24;
            4'd3:    seg_o = 7'h30;
            4'd4:    seg_o = 7'h19;
            4'd5:    seg_o = 7'h12;
            4'd6:    seg_o = 7'h02;
            4'd7:    seg_o = 7'h78;
            4'd8:    seg_o = 7'h00;
            4'd9:    seg_o = 7'h10;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_n.sv
// Binary to BCD converter (iterative shift/add-3) driving DIGITS active-low
// seven-segment displays plus a sign display, with start/busy/done handshake.
module bcd_display_n
    import bcd_disp_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int DIGITS        = 5,
    parameter bit SIGNED        = 1'b0,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  negative,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   segments,
    output logic [6:0]            sign_seg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;

    state_t           state_q;
    logic [SW-1:0]    sr_q;        // {bcd digits, remaining magnitude bits}
    logic [SW-1:0]    sr_add3_d;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;       // sticky overflow of the running conversion
    logic             sign_q;
    logic [BW-1:0]    bcd_q;
    logic             neg_q;
    logic             ovf_out_q;
    logic             done_q;

    logic             value_neg;
    logic [WIDTH-1:0] mag;
    logic [DIGITS-1:0] blank;

    // The most negative value negates to itself, which read as unsigned is its magnitude.
    assign value_neg = SIGNED & value[WIDTH-1];
    assign mag       = value_neg ? ((~value) + WIDTH'(1)) : value;

    // Add-3 correction applied to every BCD digit of 5 or more
    assign sr_add3_d[WIDTH-1:0] = sr_q[WIDTH-1:0];
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        assign sr_add3_d[WIDTH+4*gi +: 4] = (sr_q[WIDTH+4*gi +: 4] >= 4'd5)
                                            ? sr_q[WIDTH+4*gi +: 4] + 4'd3
                                            : sr_q[WIDTH+4*gi +: 4];
    end

    // Conversion FSM with registered results and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sign_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sr_q    <= {{BW{1'b0}}, mag};
                        sign_q  <= value_neg;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_ADD3;
                    end
                end
                ST_ADD3: begin
                    sr_q    <= sr_add3_d;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    sr_q  <= {sr_q[SW-2:0], 1'b0};
                    cnt_q <= cnt_q + CW'(1);
                    // A one leaving the top digit means the value needs more digits.
                    if (sr_q[SW-1]) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_LATCH;
                    end else begin
                        state_q <= ST_ADD3;
                    end
                end
                ST_LATCH: begin
                    bcd_q     <= sr_q[SW-1 -: BW];
                    neg_q     <= sign_q;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Leading-zero scan from the top digit down; digit 0 is never blanked
    always_comb begin
        logic run;
        blank = '0;
        run   = BLANK_LEADING;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run      = run && (bcd_q[4*i +: 4] == 4'd0);
            blank[i] = run;
        end
    end

    // Per-digit decode followed by overflow-dash / blank selection
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [6:0] raw_seg;
        seven_seg u_seg (
            .bcd_i (bcd_q[4*gi +: 4]),
            .seg_o (raw_seg)
        );
        assign segments[7*gi +: 7] = ovf_out_q  ? SEG_DASH  :
                                     blank[gi]  ? SEG_BLANK : raw_seg;
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign negative = neg_q;
    assign overflow = ovf_out_q;
    assign sign_seg = neg_q ? SEG_DASH : SEG_BLANK;

endmodule

// File: tb/tb_bcd_display_n.sv
// Randomised self-checking bench: three configurations checked against a
// decimal-arithmetic reference model.
module tb_bcd_display_n;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance 0: WIDTH 16, DIGITS 5, unsigned, blanking
    logic        start0;
    logic [15:0] value0;
    logic        busy0, done0, neg0, ovf0;
    logic [19:0] bcd0;
    logic [34:0] seg0;
    logic [6:0]  sgn0;
    // Instance 1: WIDTH 8, DIGITS 3, signed, blanking
    logic        start1;
    logic [7:0]  value1;
    logic        busy1, done1, neg1, ovf1;
    logic [11:0] bcd1;
    logic [20:0] seg1;
    logic [6:0]  sgn1;
    // Instance 2: WIDTH 16, DIGITS 4, unsigned, no blanking
    logic        start2;
    logic [15:0] value2;
    logic        busy2, done2, neg2, ovf2;
    logic [15:0] bcd2;
    logic [27:0] seg2;
    logic [6:0]  sgn2;

    bcd_display_n #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0), .BLANK_LEADING(1'b1)) u0 (
        .clk(clk), .reset(reset), .start(start0), .value(value0), .busy(busy0), .done(done0),
        .bcd_out(bcd0), .negative(neg0), .overflow(ovf0), .segments(seg0), .sign_seg(sgn0));
    bcd_display_n #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .reset(reset), .start(start1), .value(value1), .busy(busy1), .done(done1),
        .bcd_out(bcd1), .negative(neg1), .overflow(ovf1), .segments(seg1), .sign_seg(sgn1));
    bcd_display_n #(.WIDTH(16), .DIGITS(4), .SIGNED(1'b0), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .reset(reset), .start(start2), .value(value2), .busy(busy2), .done(done2),
        .bcd_out(bcd2), .negative(neg2), .overflow(ovf2), .segments(seg2), .sign_seg(sgn2));

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic int wof(input int i);
        return (i == 1) ? 8 : 16;
    endfunction
    function automatic int dof(input int i);
        return (i == 0) ? 5 : (i == 1) ? 3 : 4;
    endfunction
    function automatic bit sof(input int i);
        return (i == 1);
    endfunction
    function automatic bit blof(input int i);
        return (i != 2);
    endfunction

    // Result packing: [19:0] bcd, [54:20] segments, [61:55] sign, [62] neg, [63] ovf
    function automatic logic [63:0] model(input int i, input longint unsigned v);
        longint unsigned mag, q, lim;
        int w, d, hi;
        int dig[5];
        bit neg, ovf;
        logic [63:0] r;
        w   = wof(i);
        d   = dof(i);
        mag = v & ((64'd1 << w) - 64'd1);
        neg = sof(i) && (((mag >> (w - 1)) & 64'd1) != 0);
        if (neg) mag = (64'd1 << w) - mag;
        lim = 1;
        for (int k = 0; k < d; k++) lim = lim * 10;
        ovf = (mag >= lim);
        q  = mag;
        hi = 0;
        for (int k = 0; k < d; k++) begin
            dig[k] = int'(q % 10);
            q      = q / 10;
            if (dig[k] != 0) hi = k;
        end
        r = '0;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = dig[k][3:0];
            if (ovf)                  r[20 + 7*k +: 7] = 7'h3F;
            else if (blof(i) && k > hi) r[20 + 7*k +: 7] = 7'h7F;
            else                      r[20 + 7*k +: 7] = seg_tbl[dig[k]];
        end
        r[61:55] = neg ? 7'h3F : 7'h7F;
        r[62]    = neg;
        r[63]    = ovf;
        return r;
    endfunction

    function automatic logic [63:0] obs(input int i);
        logic [63:0] r;
        r = '0;
        case (i)
            0: begin r[19:0] = bcd0; r[20 +: 35] = seg0; r[61:55] = sgn0; r[62] = neg0; r[63] = ovf0; end
            1: begin r[11:0] = bcd1; r[20 +: 21] = seg1; r[61:55] = sgn1; r[62] = neg1; r[63] = ovf1; end
            default: begin r[15:0] = bcd2; r[20 +: 28] = seg2; r[61:55] = sgn2; r[62] = neg2; r[63] = ovf2; end
        endcase
        return r;
    endfunction

    function automatic logic busy_of(input int i);
        return (i == 0) ? busy0 : (i == 1) ? busy1 : busy2;
    endfunction
    function automatic logic done_of(input int i);
        return (i == 0) ? done0 : (i == 1) ? done1 : done2;
    endfunction

    task automatic drive(input int i, input logic s, input longint unsigned v);
        case (i)
            0: begin start0 = s; value0 = v[15:0]; end
            1: begin start1 = s; value1 = v[7:0]; end
            default: begin start2 = s; value2 = v[15:0]; end
        endcase
    endtask

    // Start a conversion and wait for done; lat counts negedges after the accepting edge.
    task automatic convert(input int i, input longint unsigned v,
                           output int lat, output int bcnt, output bit ok);
        @(negedge clk); drive(i, 1'b1, v);
        @(negedge clk); drive(i, 1'b0, v);
        bcnt = busy_of(i) ? 1 : 0;
        lat  = 0;
        ok   = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (done_of(i)) begin lat = n; ok = 1'b1; break; end
            if (busy_of(i)) bcnt++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs(i) !== model(i, 0) || busy_of(i) !== 1'b0 || done_of(i) !== 1'b0) begin
                bad++;
                $display("FAIL reset_state inst%0d: got %h busy=%b done=%b, expected %h busy=0 done=0",
                         i, obs(i), busy_of(i), done_of(i), model(i, 0));
            end
            $display("reset inst%0d outputs=%h", i, obs(i));
        end
    endtask

    task automatic test_list(input int i, input longint unsigned vals[$]);
        int lat, bcnt;
        bit ok;
        logic [63:0] exp_r, got_r;
        foreach (vals[k]) begin
            convert(i, vals[k], lat, bcnt, ok);
            exp_r = model(i, vals[k]);
            got_r = obs(i);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL timeout inst%0d value=%0d: no done within 200 cycles", i, vals[k]);
                continue;
            end
            if (lat != 2*wof(i) + 1) begin
                bad++;
                $display("FAIL latency inst%0d value=%0d: got %0d, expected %0d", i, vals[k], lat, 2*wof(i)+1);
            end
            total++;
            if (bcnt != 2*wof(i) + 1 || busy_of(i) !== 1'b0) begin
                bad++;
                $display("FAIL busy inst%0d value=%0d: busy cycles %0d busy_in_done=%b, expected %0d and 0",
                         i, vals[k], bcnt, busy_of(i), 2*wof(i)+1);
            end
            total++;
            if (got_r !== exp_r) begin
                bad++;
                $display("FAIL result inst%0d value=%0d: got %h, expected %h", i, vals[k], got_r, exp_r);
            end
            @(negedge clk);
            total++;
            if (done_of(i) !== 1'b0) begin
                bad++;
                $display("FAIL done_width inst%0d value=%0d: done still %b, expected 0", i, vals[k], done_of(i));
            end
            $display("conv inst%0d value=%0d lat=%0d result=%h", i, vals[k], lat, got_r);
        end
    endtask

    task automatic test_unsigned();
        longint unsigned v[$];
        v = '{65535, 0, 907, 1, 10, 100};
        for (int k = 0; k < 6; k++) v.push_back($urandom_range(0, 65535));
        test_list(0, v);
    endtask

    task automatic test_signed();
        longint unsigned v[$];
        v = '{8'h80, 8'hFF, 8'h00, 8'h7F, 8'hF6};
        for (int k = 0; k < 6; k++) v.push_back($urandom_range(0, 255));
        test_list(1, v);
    endtask

    task automatic test_overflow();
        longint unsigned v[$];
        v = '{10000, 9999, 0, 65535, 7};
        for (int k = 0; k < 4; k++) v.push_back($urandom_range(9990, 10010));
        for (int k = 0; k < 3; k++) v.push_back($urandom_range(0, 65535));
        test_list(2, v);
    endtask

    task automatic test_busy_ignore();
        longint unsigned v1;
        int dcount;
        logic [63:0] got_r;
        v1 = $urandom_range(0, 65535);
        got_r = '0;
        dcount = 0;
        @(negedge clk); drive(0, 1'b1, v1);
        @(negedge clk); drive(0, 1'b0, v1);
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (done0) begin dcount++; got_r = obs(0); end
            if ((n % 5) == 2 && n < 32) drive(0, 1'b1, $urandom_range(0, 65535));
            else                        start0 = 1'b0;
        end
        start0 = 1'b0;
        total++;
        if (dcount != 1) begin
            bad++;
            $display("FAIL busy_ignore_dones: got %0d done pulses, expected 1", dcount);
        end
        total++;
        if (got_r !== model(0, v1)) begin
            bad++;
            $display("FAIL busy_ignore_result: got %h, expected %h", got_r, model(0, v1));
        end
        $display("busy_ignore value=%0d dones=%0d result=%h", v1, dcount, got_r);
    endtask

    task automatic test_back_to_back();
        longint unsigned v1, v2;
        int lat, bcnt, gap;
        bit ok, seen;
        logic [63:0] r1, r2;
        v1 = $urandom_range(0, 65535);
        v2 = $urandom_range(0, 65535);
        convert(0, v1, lat, bcnt, ok);
        r1 = obs(0);
        drive(0, 1'b1, v2);
        @(negedge clk); start0 = 1'b0;
        gap  = 1;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done0) begin seen = 1'b1; break; end
            @(negedge clk); gap++;
        end
        r2 = obs(0);
        total++;
        if (!ok || r1 !== model(0, v1)) begin
            bad++;
            $display("FAIL b2b_first: got %h ok=%b, expected %h", r1, ok, model(0, v1));
        end
        total++;
        if (!seen || gap != 34) begin
            bad++;
            $display("FAIL b2b_gap: got %0d cycles seen=%b, expected 34", gap, seen);
        end
        total++;
        if (r2 !== model(0, v2)) begin
            bad++;
            $display("FAIL b2b_second: got %h, expected %h", r2, model(0, v2));
        end
        $display("back_to_back v1=%0d v2=%0d gap=%0d", v1, v2, gap);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, dcount;
        bit ok;
        longint unsigned v;
        convert(0, 12345, lat, bcnt, ok);
        @(negedge clk); drive(0, 1'b1, 54321);
        @(negedge clk); start0 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || obs(0) !== model(0, 0)) begin
            bad++;
            $display("FAIL reset_mid_state: got %h busy=%b done=%b, expected %h busy=0 done=0",
                     obs(0), busy0, done0, model(0, 0));
        end
        reset = 1'b0;
        dcount = 0;
        for (int n = 0; n < 45; n++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        total++;
        if (dcount != 0 || obs(0) !== model(0, 0)) begin
            bad++;
            $display("FAIL reset_mid_nodone: got %0d dones outputs %h, expected 0 and %h",
                     dcount, obs(0), model(0, 0));
        end
        $display("reset_mid dones_after=%0d", dcount);
        v = $urandom_range(0, 65535);
        convert(0, v, lat, bcnt, ok);
        total++;
        if (!ok || obs(0) !== model(0, v)) begin
            bad++;
            $display("FAIL reset_mid_recover value=%0d: got %h ok=%b, expected %h", v, obs(0), ok, model(0, v));
        end
        $display("reset_mid recover value=%0d result=%h", v, obs(0));
    endtask

    initial begin
        reset  = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        value0 = '0;   value1 = '0;   value2 = '0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        test_unsigned();
        test_signed();
        test_overflow();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
